// File: rtl/branch_predictor_if.sv
// Fetch/resolve/statistics bundle between the CPU pipeline and the predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] pc_if_i;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_pred_taken_i;
  logic [ADDR_W-1:0] upd_pred_target_i;
  logic              mispredict_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              clear_stats_i;
  logic [CNT_W-1:0]  branch_cnt_o;
  logic [CNT_W-1:0]  mispredict_cnt_o;

  modport master (
    output pc_if_i,
    input  pred_taken_o,
    input  pred_target_o,
    output upd_valid_i,
    output upd_pc_i,
    output upd_taken_i,
    output upd_target_i,
    output upd_pred_taken_i,
    output upd_pred_target_i,
    input  mispredict_o,
    input  redirect_pc_o,
    output clear_stats_i,
    input  branch_cnt_o,
    input  mispredict_cnt_o
  );

  modport slave (
    input  pc_if_i,
    output pred_taken_o,
    output pred_target_o,
    input  upd_valid_i,
    input  upd_pc_i,
    input  upd_taken_i,
    input  upd_target_i,
    input  upd_pred_taken_i,
    input  upd_pred_target_i,
    output mispredict_o,
    output redirect_pc_o,
    input  clear_stats_i,
    output branch_cnt_o,
    output mispredict_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; lookup in IF,
// update and mispredict detection from MEM, plus saturating statistics.
module branch_predictor #(
  parameter int         ADDR_W   = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  branch_predictor_if.slave  bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [CNT_W-1:0]   branch_cnt_q;
  logic [CNT_W-1:0]   mispredict_cnt_q;

  logic [IDX_W-1:0]   l_idx;
  logic [TAG_W-1:0]   l_tag;
  logic               l_hit;
  logic               l_taken;

  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit;
  logic [ADDR_W-1:0]  u_seq;
  logic [ADDR_W-1:0]  u_next;
  logic               mispredict;

  assign l_idx   = bp.pc_if_i[IDX_W+1:2];
  assign l_tag   = bp.pc_if_i[ADDR_W-1:IDX_W+2];
  assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign l_taken = l_hit && ctr_q[l_idx][1];

  assign bp.pred_taken_o  = l_taken;
  assign bp.pred_target_o = l_taken ? target_q[l_idx]
                                    : bp.pc_if_i + ADDR_W'(4);

  assign u_idx  = bp.upd_pc_i[IDX_W+1:2];
  assign u_tag  = bp.upd_pc_i[ADDR_W-1:IDX_W+2];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_seq  = bp.upd_pc_i + ADDR_W'(4);
  assign u_next = bp.upd_taken_i ? bp.upd_target_i : u_seq;

  // Wrong direction, or right direction (taken) but wrong target.
  assign mispredict = bp.upd_valid_i &&
    ((bp.upd_pred_taken_i != bp.upd_taken_i) ||
     (bp.upd_taken_i &&
      (bp.upd_pred_target_i != bp.upd_target_i)));

  assign bp.mispredict_o  = mispredict;
  assign bp.redirect_pc_o = bp.upd_valid_i ? u_next : u_seq;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= CTR_INIT;
    end else if (bp.upd_valid_i) begin
      if (u_hit) begin
        if (bp.upd_taken_i) begin
          if (ctr_q[u_idx] != 2'b11)
            ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          target_q[u_idx] <= bp.upd_target_i;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (bp.upd_taken_i) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= bp.upd_target_i;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || bp.clear_stats_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (bp.upd_valid_i && branch_cnt_q != '1)
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (mispredict && mispredict_cnt_q != '1)
        mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
    end
  end

  assign bp.branch_cnt_o     = branch_cnt_q;
  assign bp.mispredict_cnt_o = mispredict_cnt_q;
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the five-stage pipelined CPU: a direct-mapped branch target buffer with a 2-bit saturating counter per entry. It is looked up combinationally with the IF-stage PC to choose the next fetch address. It is updated from the MEM stage, where branches resolve. It replaces the CPU's fixed predict-not-taken policy and raises a one-cycle mispredict/redirect that drives the existing IF/ID, ID/EX and EX/MEM flushes.

## Interface
- ADDR_W, 32, PC width; bits [1:0] ignored.
- ENTRIES, 16, table depth; power of two, ≥2; IDX_W = log2(ENTRIES), TAG_W = ADDR_W-2-IDX_W.
- CTR_INIT, 2'b01, counter value after reset.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; **synchronous, active-low**.
- pc_if_i  in  ADDR_W  IF-stage fetch PC.
- pred_taken_o  out  1  prediction for pc_if_i (combinational).
- pred_target_o  out  ADDR_W  next fetch PC (combinational).
- upd_valid_i  in  1  a branch resolves in MEM this cycle.
- upd_pc_i  in  ADDR_W  PC of the resolving branch.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_pred_taken_i  in  1  prediction carried down the pipe with the branch.
- upd_pred_target_i  in  ADDR_W  predicted next PC carried down the pipe.
- mispredict_o  out  1  flush request (combinational).
- redirect_pc_o  out  ADDR_W  correct next PC (combinational).
- clear_stats_i  in  1  synchronous clear of the statistics counters.
- branch_cnt_o  out  CNT_W  resolved branches, saturating.
- mispredict_cnt_o  out  CNT_W  mispredictions, saturating.

## Operation
- Entry contents: valid, tag[TAG_W], target[ADDR_W], ctr[1:0].
- Index and tag for PC p:
  - idx = p[IDX_W+1:2]
  - tag = p[ADDR_W-1:IDX_W+2]
- Lookup:
  - hit = valid[idx] & (tag match).
  - pred_taken_o = hit & ctr[1].
  - pred_target_o = pred_taken_o ? target : pc_if_i+4.
  - Adders are ADDR_W wide and wrap modulo 2^ADDR_W.
- Resolution (valid only while upd_valid_i=1; otherwise mispredict_o=0 and redirect_pc_o = upd_pc_i+4):
  - actual_next = upd_taken_i ? upd_target_i : upd_pc_i+4.
  - mispredict_o = (upd_pred_taken_i != upd_taken_i) | (upd_taken_i & upd_pred_target_i != upd_target_i).
  - redirect_pc_o = actual_next.
- Update on an edge with rst_i=1 and upd_valid_i=1, using the index/tag of upd_pc_i:
  - hit, taken: ctr = min(ctr+1, 3); target = upd_target_i.
  - hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - miss, taken: allocate, overwriting any alias. valid=1, tag written, target = upd_target_i, ctr = 2'b10.
  - miss, not taken: no change.
- Counter FSM: 00 strong-NT ↔ 01 weak-NT ↔ 10 weak-T ↔ 11 strong-T. Taken moves right, not-taken moves left, saturating at both ends.
- Statistics, on each edge with rst_i=1:
  - clear_stats_i=1: both counters go to 0. This takes priority over an increment in the same cycle.
  - Otherwise, upd_valid_i increments branch_cnt_o, and mispredict_o increments mispredict_cnt_o.
  - Both saturate at 2^CNT_W-1.

## Timing
- Lookup and resolution outputs are purely combinational; zero latency.
- A table write becomes visible to lookups from the cycle after the update edge.
- A same-cycle lookup of the index being updated returns the old contents.
- Reset (rst_i=0 at an edge):
  - All valid bits and both statistics counters clear; all ctr = CTR_INIT.
  - upd_valid_i and clear_stats_i are ignored during that edge.
  - While rst_i=0, pred_taken_o=0 and pred_target_o=pc_if_i+4, because all entries read invalid from the first reset edge.
- Reset asserted mid-operation discards any in-flight update. After release, the first edge takes updates normally.
- The CPU must assert upd_valid_i for exactly one cycle per resolving branch. The predictor keeps no record of duplicates.

## Test plan
- Reset, then pc_if_i=0x40 → pred_taken_o=0, pred_target_o=0x44, both statistics counters 0.
- Update pc=0x40, taken, target=0x10, pred_taken=0 → mispredict_o=1, redirect_pc_o=0x10. Next cycle, lookup 0x40 → pred_taken_o=1, target 0x10; counts 1/1.
- Hysteresis:
  - Two more taken updates at 0x40 → ctr=11.
  - One not-taken with pred_taken=1 → mispredict_o=1, redirect 0x44; lookup still taken (ctr 10).
  - Second not-taken → lookup 0x40 not taken (ctr 01).
- Aliasing (ENTRIES=16): allocate 0x40, then lookup 0x80 (same idx 0, different tag) → miss, target 0x84. Taken update at 0x80 evicts it, after which 0x40 misses.
- Same-cycle lookup and update at 0x40 → old prediction that cycle, new one the next. Taken hit with wrong predicted target → mispredict_o=1.
- Statistics counters preset near saturation (CNT_W=4): counts stop at 15. clear_stats_i concurrent with upd_valid_i → 0. rst_i=0 during upd_valid_i → table unchanged, counts 0.
